// File: rtl/gate_stim_checker.sv
// Stimulus/response checker wrapped around the gate1 two-input gate block.
// Walks {a,b} through 00..11, samples res after a settle window and counts truth-table mismatches.
module gate_stim_checker #(
   parameter int SETTLE_CYCLES = 2,
   parameter int LOOPS         = 1,
   parameter int ERR_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             a,
   output logic             b,
   input  logic [7:0]       res,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [1:0]       fail_ab,
   output logic [7:0]       fail_mask,
   output logic [2:0]       state_dbg
);

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;
   localparam logic [SW-1:0]    SETTLE_LOAD = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
   localparam logic [LW-1:0]    LAST_LOOP   = LW'(LOOPS - 1);
   localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DRIVE  = 3'd1,
      SETTLE = 3'd2,
      CHECK  = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t           state, state_d;
   logic [1:0]       idx, idx_d;
   logic [LW-1:0]    loop_cnt, loop_d;
   logic [SW-1:0]    settle_cnt, settle_d;
   logic [ERR_W-1:0] err_d;
   logic [1:0]       fail_ab_d;
   logic [7:0]       fail_mask_d;
   logic [7:0]       exp_res;
   logic             mismatch;

   // a/b come straight from the registered vector index, so they never depend on res.
   assign a = idx[1];
   assign b = idx[0];

   always_comb begin
      exp_res  = {a & b, a | b, ~(a & b), ~(a | b), a ^ b, ~(a ^ b), ~a, ~b};
      mismatch = (res != exp_res);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= 2'd0;
         loop_cnt   <= '0;
         settle_cnt <= '0;
         err_count  <= '0;
         fail_ab    <= 2'd0;
         fail_mask  <= 8'd0;
      end else begin
         state      <= state_d;
         idx        <= idx_d;
         loop_cnt   <= loop_d;
         settle_cnt <= settle_d;
         err_count  <= err_d;
         fail_ab    <= fail_ab_d;
         fail_mask  <= fail_mask_d;
      end
   end

   always_comb begin
      state_d     = state;
      idx_d       = idx;
      loop_d      = loop_cnt;
      settle_d    = settle_cnt;
      err_d       = err_count;
      fail_ab_d   = fail_ab;
      fail_mask_d = fail_mask;

      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_d     = DRIVE;
               idx_d       = 2'd0;
               loop_d      = '0;
               err_d       = '0;
               fail_ab_d   = 2'd0;
               fail_mask_d = 8'd0;
            end
         end
         DRIVE: begin
            if (SETTLE_CYCLES == 0) begin
               state_d = CHECK;
            end else begin
               state_d  = SETTLE;
               settle_d = SETTLE_LOAD;
            end
         end
         SETTLE: begin
            if (settle_cnt == '0) state_d = CHECK;
            else                  settle_d = settle_cnt - SW'(1);
         end
         CHECK: begin
            if (mismatch) begin
               if (err_count != ERR_MAX) err_d = err_count + ERR_W'(1);
               fail_ab_d   = idx;
               fail_mask_d = res ^ exp_res;
            end
            if (idx == 2'd3 && loop_cnt == LAST_LOOP) begin
               state_d = DONE;
            end else begin
               state_d = DRIVE;
               idx_d   = idx + 2'd1;
               if (idx == 2'd3) loop_d = loop_cnt + LW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy      = (state == DRIVE) || (state == SETTLE) || (state == CHECK);
   assign done      = (state == DONE);
   assign pass      = done && (err_count == '0);
   assign state_dbg = state;

endmodule

// File: tb/tb_gate_stim_checker.sv
// Bench for gate_stim_checker: three parameterisations run against a cycle-count model
// that predicts every output from elapsed cycles since start.
module tb_gate_stim_checker;
   localparam int N = 3;
   int s_cfg [N] = '{2, 0, 1};
   int l_cfg [N] = '{1, 3, 2};
   int e_cfg [N] = '{8, 8, 2};
   int exp_lat [N] = '{16, 24, 24};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N-1:0] start = '0;
   logic [N-1:0] a_o, b_o, busy, done, pass;
   logic [7:0] res [N];
   logic [7:0] clr [N];
   logic [7:0] flip [N];
   logic [7:0] err0, err1;
   logic [1:0] err2;
   logic [1:0] fab [N];
   logic [7:0] fmask [N];
   logic [2:0] sdbg [N];

   int total = 0;
   int bad = 0;
   int lat [N];

   bit m_run [N];
   bit m_done [N];
   int m_e [N], m_err [N], m_fab [N], m_fmask [N], m_hold [N];

   always #5 clk = ~clk;

   gate_stim_checker #(.SETTLE_CYCLES(2), .LOOPS(1), .ERR_W(8)) u0 (
      .clk(clk), .rst(rst), .start(start[0]), .a(a_o[0]), .b(b_o[0]), .res(res[0]),
      .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err0),
      .fail_ab(fab[0]), .fail_mask(fmask[0]), .state_dbg(sdbg[0]));
   gate_stim_checker #(.SETTLE_CYCLES(0), .LOOPS(3), .ERR_W(8)) u1 (
      .clk(clk), .rst(rst), .start(start[1]), .a(a_o[1]), .b(b_o[1]), .res(res[1]),
      .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err1),
      .fail_ab(fab[1]), .fail_mask(fmask[1]), .state_dbg(sdbg[1]));
   gate_stim_checker #(.SETTLE_CYCLES(1), .LOOPS(2), .ERR_W(2)) u2 (
      .clk(clk), .rst(rst), .start(start[2]), .a(a_o[2]), .b(b_o[2]), .res(res[2]),
      .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(err2),
      .fail_ab(fab[2]), .fail_mask(fmask[2]), .state_dbg(sdbg[2]));

   // Ideal gate1 truth table from arithmetic on the 0/1 inputs.
   function automatic logic [7:0] gate_model(input int v);
      int ai, bi, g_and, g_or, g_xor;
      ai = v / 2;
      bi = v % 2;
      g_and = ai * bi;
      g_or  = (ai + bi > 0) ? 1 : 0;
      g_xor = (ai + bi == 1) ? 1 : 0;
      return {g_and[0], g_or[0], ~g_and[0], ~g_or[0], g_xor[0], ~g_xor[0], ~ai[0], ~bi[0]};
   endfunction

   always_comb begin
      for (int i = 0; i < N; i++)
         res[i] = (gate_model(int'({a_o[i], b_o[i]})) & ~clr[i]) ^ flip[i];
   end

   function automatic int err_of(input int i);
      case (i)
         0: return int'(err0);
         1: return int'(err1);
         default: return int'(err2);
      endcase
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset(input int i);
      m_run[i] = 0; m_done[i] = 0; m_e[i] = 0; m_err[i] = 0;
      m_fab[i] = 0; m_fmask[i] = 0; m_hold[i] = 0;
   endtask

   task automatic model_step(input int i);
      int per, tot, maxe, v, diff;
      per  = s_cfg[i] + 2;
      tot  = 4 * l_cfg[i] * per;
      maxe = (1 << e_cfg[i]) - 1;
      if (m_run[i]) begin
         if (m_e[i] % per == per - 1) begin
            v = (m_e[i] / per) % 4;
            diff = int'(res[i] ^ gate_model(v));
            if (diff != 0) begin
               if (m_err[i] < maxe) m_err[i]++;
               m_fab[i] = v;
               m_fmask[i] = diff;
            end
         end
         m_e[i]++;
         if (m_e[i] == tot) begin
            m_run[i] = 0; m_done[i] = 1; m_hold[i] = 3;
         end
      end else if (start[i]) begin
         m_run[i] = 1; m_done[i] = 0; m_e[i] = 0; m_err[i] = 0;
         m_fab[i] = 0; m_fmask[i] = 0;
      end
   endtask

   // Compare every cycle on the falling edge, then advance the model with the inputs
   // that the next rising edge will sample.
   always @(negedge clk) begin
      int exp_ab;
      if (rst) for (int i = 0; i < N; i++) model_reset(i);
      for (int i = 0; i < N; i++) begin
         exp_ab = m_run[i] ? (m_e[i] / (s_cfg[i] + 2)) % 4 : m_hold[i];
         check($sformatf("u%0d.ab", i), int'({a_o[i], b_o[i]}), exp_ab);
         check($sformatf("u%0d.busy", i), int'(busy[i]), int'(m_run[i]));
         check($sformatf("u%0d.done", i), int'(done[i]), int'(m_done[i]));
         check($sformatf("u%0d.pass", i), int'(pass[i]), (m_done[i] && m_err[i] == 0) ? 1 : 0);
         check($sformatf("u%0d.err_count", i), err_of(i), m_err[i]);
         check($sformatf("u%0d.fail_ab", i), int'(fab[i]), m_fab[i]);
         check($sformatf("u%0d.fail_mask", i), int'(fmask[i]), m_fmask[i]);
      end
      if (!rst) for (int i = 0; i < N; i++) model_step(i);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start on the masked instances and record cycles from start edge to done.
   task automatic launch(input logic [N-1:0] m, input int budget);
      for (int i = 0; i < N; i++) lat[i] = -1;
      start = m;
      tick();
      start = '0;
      for (int c = 1; c <= budget; c++) begin
         tick();
         for (int i = 0; i < N; i++)
            if (m[i] && done[i] && lat[i] < 0) lat[i] = c;
      end
      for (int i = 0; i < N; i++)
         if (m[i]) check($sformatf("u%0d.latency", i), lat[i], exp_lat[i]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         clr[i] = 8'h00;
         flip[i] = 8'h00;
      end
      repeat (3) tick();
      rst = 1'b0;
      check("reset.busy", int'(busy), 0);
      check("reset.done", int'(done), 0);
      check("reset.ab0", int'({a_o[0], b_o[0]}), 0);

      // Ideal gate on every instance.
      launch(3'b111, 30);
      check("ideal.pass", int'(pass), 7);
      check("ideal.err0", int'(err0), 0);

      // xor stuck-0 on u0; everything inverted on u2 (saturating 2-bit counter).
      clr[0] = 8'h08;
      flip[2] = 8'hFF;
      launch(3'b111, 30);
      check("xor0.err", int'(err0), 2);
      check("xor0.fail_ab", int'(fab[0]), 2);
      check("xor0.fail_mask", int'(fmask[0]), 8'h08);
      check("xor0.pass", int'(pass[0]), 0);
      check("ideal_u1.pass", int'(pass[1]), 1);
      check("inv.err", int'(err2), 3);
      check("inv.pass", int'(pass[2]), 0);
      check("inv.fail_mask", int'(fmask[2]), 8'hFF);
      clr[0] = 8'h00;
      flip[2] = 8'h00;

      // Reset during SETTLE of vector 2, then a clean run.
      start = 3'b001;
      tick();
      start = '0;
      repeat (9) tick();
      check("mid.ab", int'({a_o[0], b_o[0]}), 2);
      check("mid.busy", int'(busy[0]), 1);
      rst = 1'b1;
      #2;
      check("arst.busy", int'(busy), 0);
      check("arst.done", int'(done), 0);
      check("arst.ab0", int'({a_o[0], b_o[0]}), 0);
      check("arst.err0", int'(err0), 0);
      tick();
      rst = 1'b0;
      launch(3'b001, 30);
      check("after_rst.pass", int'(pass[0]), 1);

      // Start held through a run; held start relaunches from DONE with counters cleared.
      clr[0] = 8'h08;
      start = 3'b011;
      tick();
      repeat (16) tick();
      check("held.done", int'(done[0]), 1);
      check("held.err", int'(err0), 2);
      clr[0] = 8'h00;
      tick();
      check("relaunch.done", int'(done[0]), 0);
      check("relaunch.busy", int'(busy[0]), 1);
      check("relaunch.err", int'(err0), 0);
      start = 3'b010;
      tick();
      start = '0;
      repeat (30) tick();

      // Random starts, bit flips, stuck bits and occasional resets.
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < N; i++) begin
            start[i] = ($urandom_range(0, 7) == 0);
            flip[i]  = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            clr[i]   = ($urandom_range(0, 9) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
         end
         rst = ($urandom_range(0, 399) == 0);
         tick();
      end
      rst = 1'b0;
      start = '0;
      for (int i = 0; i < N; i++) begin
         flip[i] = 8'h00;
         clr[i] = 8'h00;
      end
      repeat (5) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
